// File: rtl/result_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_dump
// Purpose  : Streams every 32-bit systolic-array result to the UART, MSB first.
// Revision : 1.0  initial release
// ============================================================================
module result_uart_dump #(
  parameter int N      = 2,
  parameter int ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     ram_c_addr,
  output logic [N*N-1:0]        ram_c_rden,
  input  logic [32*N*N-1:0]     ram_c_q,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_send_data,
  input  logic                  uart_tx_done
);

  localparam int              c_NB     = N * N;
  localparam int              c_KW     = (c_NB > 1) ? $clog2(c_NB) : 1;
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_NB - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_REQ  = 3'd1;
  localparam logic [2:0] c_RD_WAIT = 3'd2;
  localparam logic [2:0] c_LATCH   = 3'd3;
  localparam logic [2:0] c_SEND    = 3'd4;
  localparam logic [2:0] c_WAIT_TX = 3'd5;
  localparam logic [2:0] c_NEXT    = 3'd6;
  localparam logic [2:0] c_DONE    = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W:0]   r_a;
  logic [ADDR_W:0]   r_num;
  logic [c_KW-1:0]   r_k;
  logic [1:0]        r_b;
  logic [31:0]       r_shreg;
  logic [7:0]        r_tx_data;
  logic [ADDR_W:0]   w_a_inc;
  logic              w_k_wrap;
  logic              w_last;
  logic [31:0]       w_slice;

  assign w_a_inc  = r_a + {{ADDR_W{1'b0}}, 1'b1};
  assign w_k_wrap = (r_k == c_K_LAST);
  assign w_last   = w_k_wrap && (w_a_inc >= r_num);
  assign w_slice  = ram_c_q[32*int'(r_k) +: 32];

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // A zero-length dump detours through NEXT (with k preset to the last bank)
  // so that done lands two cycles after start, same as a finished dump.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (start) w_next = (num_words == '0) ? c_NEXT : c_RD_REQ;
      c_RD_REQ:  w_next = c_RD_WAIT;
      c_RD_WAIT: w_next = c_LATCH;
      c_LATCH:   w_next = c_SEND;
      c_SEND:    w_next = c_WAIT_TX;
      c_WAIT_TX: if (uart_tx_done) w_next = (r_b == 2'd3) ? c_NEXT : c_SEND;
      c_NEXT:    w_next = w_last ? c_DONE : c_RD_REQ;
      c_DONE:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state != c_IDLE);
    done           = (r_state == c_DONE);
    uart_send_data = (r_state == c_SEND);
    ram_c_rden     = '0;
    if (r_state == c_RD_REQ) ram_c_rden[r_k] = 1'b1;
  end

  assign ram_c_addr   = r_a[ADDR_W-1:0];
  assign uart_tx_data = r_tx_data;

  // tx_data is loaded on entry to SEND so it is stable while the strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_num     <= '0;
      r_k       <= '0;
      r_b       <= '0;
      r_shreg   <= '0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_num <= num_words;
            r_a   <= '0;
            r_k   <= (num_words == '0) ? c_K_LAST : '0;
          end
        end
        c_LATCH: begin
          r_shreg   <= w_slice;
          r_b       <= '0;
          r_tx_data <= w_slice[31:24];
        end
        c_WAIT_TX: begin
          if (uart_tx_done) begin
            r_shreg <= {r_shreg[23:0], 8'h00};
            r_b     <= r_b + 2'd1;
            if (r_b != 2'd3) r_tx_data <= r_shreg[23:16];
          end
        end
        c_NEXT: begin
          r_k <= w_k_wrap ? '0 : r_k + 1'b1;
          if (w_k_wrap) r_a <= w_a_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_uart_dump
// Purpose  : Self-checking bench: vector table, random data, reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_uart_dump;

  localparam int N  = 2;
  localparam int NN = N * N;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW:0]     num_words = '0;
  logic            busy;
  logic            done;
  logic [AW-1:0]   ram_c_addr;
  logic [NN-1:0]   ram_c_rden;
  logic [32*NN-1:0] ram_c_q;
  logic [7:0]      uart_tx_data;
  logic            uart_send_data;
  logic            uart_tx_done = 1'b0;

  always #5 clk = ~clk;

  result_uart_dump #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .ram_c_addr(ram_c_addr), .ram_c_rden(ram_c_rden),
    .ram_c_q(ram_c_q), .uart_tx_data(uart_tx_data),
    .uart_send_data(uart_send_data), .uart_tx_done(uart_tx_done)
  );

  // Result RAM model: q is valid two cycles after the read request.
  logic [31:0]   mem [NN][16];
  logic [AW-1:0] st1 = '0;
  logic [AW-1:0] st2 = '0;
  always @(posedge clk) begin
    if (|ram_c_rden) st1 <= ram_c_addr;
    st2 <= st1;
  end
  always_comb begin
    ram_c_q = '0;
    for (int k = 0; k < NN; k++) ram_c_q[32*k +: 32] = mem[k][st2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART responder and output monitor
  int         lat = 1;
  bit         spur = 1'b0;
  int         cnt = 0;
  logic [7:0] sent_b[$];
  int         sent_c[$];
  int         rd_a[$];
  int         rd_v[$];
  int         done_c[$];

  initial forever begin
    @(negedge clk);
    uart_tx_done = (cnt == 1) || (cnt == 0 && spur && ($urandom_range(0, 1) == 1));
    if (cnt > 0) cnt--;
    if (uart_send_data) begin
      sent_b.push_back(uart_tx_data);
      sent_c.push_back(cyc);
      cnt = lat;
    end
    if (ram_c_rden != '0) begin
      rd_a.push_back(int'(ram_c_addr));
      rd_v.push_back(int'(ram_c_rden));
    end
    if (done) done_c.push_back(cyc);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int nw;
    int mode;
    int lat;
    bit spur;
    bit bstart;
    int exp_bytes;
    int exp_done;
  } vec_t;

  logic [31:0] single_vals [NN];

  task automatic fill(input int mode);
    for (int k = 0; k < NN; k++)
      for (int a = 0; a < 16; a++)
        case (mode)
          0:       mem[k][a] = single_vals[k];
          1:       mem[k][a] = {8'(k), 8'(a), 8'hA5, 8'h5A};
          default: mem[k][a] = $urandom;
        endcase
  endtask

  task automatic clear_mon();
    sent_b.delete(); sent_c.delete(); rd_a.delete(); rd_v.delete(); done_c.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int         s, done_at, t, nb, nr;
    bit         got;
    logic [7:0] exp_b[$];
    logic [31:0] w;
    fill(v.mode);
    lat  = v.lat;
    spur = v.spur;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    num_words = (AW+1)'(v.nw);
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 1'b0;
    done_at = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        done_at = cyc;
      end else begin
        if (v.bstart) begin
          start = ($urandom_range(0, 2) == 0);
          num_words = (AW+1)'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    spur  = 1'b0;
    chk("done_seen", got, 1);
    chk("done_latency", done_at - s, v.exp_done);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    repeat (v.lat + 3) @(negedge clk);
    chk("done_pulses", done_c.size(), 1);

    // Reference stream: address-major, bank next, bytes MSB first.
    for (int a = 0; a < v.nw; a++)
      for (int k = 0; k < NN; k++) begin
        w = mem[k][a];
        for (int b = 3; b >= 0; b--) exp_b.push_back(w[8*b +: 8]);
      end
    chk("byte_count", sent_b.size(), v.exp_bytes);
    chk("model_count", exp_b.size(), sent_b.size());
    nb = (sent_b.size() < exp_b.size()) ? sent_b.size() : exp_b.size();
    t = s + 4;
    for (int j = 0; j < nb; j++) begin
      chk($sformatf("byte[%0d]", j), sent_b[j], exp_b[j]);
      chk($sformatf("send_cycle[%0d]", j), sent_c[j] - s, t - s);
      t += ((j % 4) == 3) ? v.lat + 5 : v.lat + 1;
    end
    chk("read_count", rd_a.size(), v.nw * NN);
    nr = (rd_a.size() < v.nw * NN) ? rd_a.size() : v.nw * NN;
    for (int i = 0; i < nr; i++) begin
      chk($sformatf("rd_addr[%0d]", i), rd_a[i], i / NN);
      chk($sformatf("rd_en[%0d]", i), rd_v[i], 1 << (i % NN));
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    single_vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    //            nw mode lat spur bstart bytes done
    tbl[0] = '{1, 0, 10, 1'b0, 1'b0,  16, 193};
    tbl[1] = '{3, 1,  3, 1'b0, 1'b0,  48, 241};
    tbl[2] = '{0, 0,  1, 1'b0, 1'b0,   0,   2};
    tbl[3] = '{1, 0, 10, 1'b1, 1'b1,  16, 193};
    tbl[4] = '{1, 0,  1, 1'b0, 1'b0,  16,  49};
    tbl[5] = '{5, 2,  2, 1'b0, 1'b0,  80, 321};
    tbl[6] = '{2, 2,  4, 1'b1, 1'b1,  32, 193};
    tbl[7] = '{8, 1,  1, 1'b0, 1'b0, 128, 385};
    rv     = '{1, 0,  3, 1'b0, 1'b0,  16,  81};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_c_addr, 0);
    chk("rst_rden", ram_c_rden, 0);
    chk("rst_tx_data", uart_tx_data, 0);
    chk("rst_send", uart_send_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset in the middle of a dump, then a clean replay.
    fill(0);
    lat  = 3;
    spur = 1'b0;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    num_words = (AW+1)'(1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && sent_b.size() < 6; i++) @(negedge clk);
    chk("mid_six_bytes", sent_b.size() >= 6, 1);
    if (sent_b.size() >= 6) begin
      chk("mid_byte0", sent_b[0], 8'h3F);
      chk("mid_byte4", sent_b[4], 8'h40);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", ram_c_addr, 0);
    chk("mid_rst_rden", ram_c_rden, 0);
    chk("mid_rst_tx_data", uart_tx_data, 0);
    chk("mid_rst_send", uart_send_data, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_done", done_c.size(), 0);
    run_vec(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected the run to finish first");
    $fatal(1);
  end

endmodule
`default_nettype wire
